// File: rtl/mipi_cal_pkg.sv
// Shared state encodings, counter widths and the pass-window search used by the phase calibrator.
// Pure definitions: no latency, no flow control.
package mipi_cal_pkg;

  localparam int POS_W   = 4;
  localparam int TO_W    = 16;
  localparam int DWELL_W = 20;
  localparam int MAP_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DWELL,
    ST_STEP_REQ,
    ST_STEP_ACK,
    ST_EVAL,
    ST_MOVE,
    ST_DONE
  } cal_state_t;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_REQ,
    HS_ACK
  } hs_state_t;

  // Centre of the longest run of passing positions; a strict '>' keeps the lowest start on ties.
  function automatic logic [POS_W-1:0] best_target(input logic [MAP_W-1:0] map, input int n);
    int best_len;
    int best_st;
    int cur_len;
    int cur_st;
    best_len = 0;
    best_st  = 0;
    cur_len  = 0;
    cur_st   = 0;
    for (int i = 0; i < MAP_W; i++) begin
      if ((i < n) && map[i]) begin
        if (cur_len == 0) cur_st = i;
        cur_len = cur_len + 1;
        if (cur_len > best_len) begin
          best_len = cur_len;
          best_st  = cur_st;
        end
      end else begin
        cur_len = 0;
      end
    end
    if (best_len == 0) return '0;
    return POS_W'(best_st + (best_len - 1) / 2);
  endfunction

endpackage

// File: rtl/phase_cal_ctrl_if.sv
// Step-request channel between the calibrator and its PLL handshake engine, plus the PLL pins.
// master issues go/dir, slave answers busy/ok/timeout and drives the PLL; pll is the PLL-side view.
interface phase_cal_ctrl_if;
  logic go;
  logic dir;
  logic busy;
  logic ok;
  logic timeout;
  logic phasestep;
  logic phaseupdown;
  logic phasedone;

  modport master (output go, dir, input busy, ok, timeout);
  modport slave  (input go, dir, phasedone, output busy, ok, timeout, phasestep, phaseupdown);
  modport pll    (input phasestep, phaseupdown, output phasedone);
endinterface

// File: rtl/pll_step_hs.sv
// One PLL phase step: hold phasestep until phasedone drops, then wait for it to rise again.
// Each wait is bounded by STEP_TO+1 cycles; go is ignored while busy.
module pll_step_hs #(
  parameter int STEP_TO = 255
) (
  input  logic           clk,
  input  logic           rst_i,
  phase_cal_ctrl_if.slave hs
);
  import mipi_cal_pkg::*;

  hs_state_t       r_state;
  hs_state_t       w_state_nxt;
  logic [TO_W-1:0] r_wait_cnt;
  logic            r_step;
  logic            r_dir;
  logic            w_waiting;
  logic            w_expired;

  always_comb begin
    w_waiting   = ((r_state == HS_REQ) && hs.phasedone) || ((r_state == HS_ACK) && !hs.phasedone);
    w_expired   = w_waiting && (r_wait_cnt == TO_W'(STEP_TO));
    w_state_nxt = r_state;
    case (r_state)
      HS_IDLE: if (hs.go) w_state_nxt = HS_REQ;
      HS_REQ: begin
        if (!hs.phasedone)  w_state_nxt = HS_ACK;
        else if (w_expired) w_state_nxt = HS_IDLE;
      end
      HS_ACK: begin
        if (hs.phasedone)   w_state_nxt = HS_IDLE;
        else if (w_expired) w_state_nxt = HS_IDLE;
      end
      default: w_state_nxt = HS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) r_state <= HS_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_wait_cnt <= '0;
      r_step     <= 1'b0;
      r_dir      <= 1'b0;
    end else begin
      if (r_state != w_state_nxt) r_wait_cnt <= '0;
      else if (w_waiting)         r_wait_cnt <= r_wait_cnt + TO_W'(1);
      r_step <= (w_state_nxt == HS_REQ);
      if ((r_state == HS_IDLE) && hs.go) r_dir <= hs.dir;
    end
  end

  assign hs.busy        = (r_state != HS_IDLE);
  assign hs.ok          = (r_state == HS_ACK) && hs.phasedone;
  assign hs.timeout     = w_expired;
  assign hs.phasestep   = r_step;
  assign hs.phaseupdown = r_dir;

endmodule

// File: rtl/phase_cal_ctrl.sv
// Sweeps NUM_PH PLL phases, scores each over DWELL cycles of err_i, then steps back to the centre
// of the widest passing window; the PLL paces every step via phasedone, lock loss aborts to DONE.
module phase_cal_ctrl
  import mipi_cal_pkg::*;
#(
  parameter int         NUM_PH  = 8,
  parameter int         DWELL   = 1024,
  parameter int         STEP_TO = 255,
  parameter logic [2:0] CNT_SEL = 3'b000
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       pll_lock,
  input  logic       cal_start,
  input  logic       err_i,
  input  logic       phasedone,
  output logic [2:0] phasecounterselect,
  output logic       phasestep,
  output logic       phaseupdown,
  output logic       cal_busy,
  output logic       cal_done,
  output logic       cal_fail,
  output logic [3:0] best_phase
);

  cal_state_t         r_state;
  cal_state_t         w_state_nxt;
  logic [POS_W-1:0]   r_pos;
  logic [POS_W-1:0]   r_target;
  logic [POS_W-1:0]   r_best;
  logic [NUM_PH-1:0]  r_map;
  logic [DWELL_W-1:0] r_dwell_cnt;
  logic               r_err_seen;
  logic               r_up;
  logic               r_fail;
  logic               w_start;
  logic               w_lock_lost;
  logic               w_dwell_last;
  logic               w_dwell_pass;
  logic               w_go;
  logic               w_hs_rst;
  logic [NUM_PH-1:0]  w_pos_bit;
  logic [POS_W-1:0]   w_eval_target;

  phase_cal_ctrl_if w_hs_if ();

  assign w_hs_rst          = rst_i | w_lock_lost;
  assign w_hs_if.go        = w_go;
  assign w_hs_if.dir       = r_up;
  assign w_hs_if.phasedone = phasedone;

  pll_step_hs #(.STEP_TO(STEP_TO)) u_step_hs (
    .clk   (clk),
    .rst_i (w_hs_rst),
    .hs    (w_hs_if.slave)
  );

  always_comb begin
    w_start       = cal_start && pll_lock;
    // DONE is excluded so a dropped lock cannot hold the block in DONE and repeat cal_done.
    w_lock_lost   = (r_state != ST_IDLE) && (r_state != ST_DONE) && !pll_lock;
    w_dwell_last  = (r_dwell_cnt == DWELL_W'(DWELL - 1));
    w_dwell_pass  = !(r_err_seen | err_i);
    w_pos_bit     = NUM_PH'(1) << r_pos;
    w_eval_target = best_target(MAP_W'(r_map), NUM_PH);
    w_go          = 1'b0;
    w_state_nxt   = r_state;
    if (w_lock_lost) begin
      w_state_nxt = ST_DONE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_start) w_state_nxt = ST_DWELL;
        ST_DWELL: begin
          if (w_dwell_last)
            w_state_nxt = (r_pos < POS_W'(NUM_PH - 1)) ? ST_STEP_REQ : ST_EVAL;
        end
        ST_STEP_REQ: begin
          w_go = 1'b1;
          if (w_hs_if.busy) w_state_nxt = ST_STEP_ACK;
        end
        ST_STEP_ACK: begin
          if (w_hs_if.timeout) w_state_nxt = ST_DONE;
          else if (w_hs_if.ok) w_state_nxt = r_up ? ST_DWELL : ST_MOVE;
        end
        ST_EVAL: w_state_nxt = ST_MOVE;
        ST_MOVE: w_state_nxt = (r_pos == r_target) ? ST_DONE : ST_STEP_REQ;
        ST_DONE: w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_pos       <= '0;
      r_target    <= '0;
      r_best      <= '0;
      r_map       <= '0;
      r_dwell_cnt <= '0;
      r_err_seen  <= 1'b0;
      r_up        <= 1'b0;
      r_fail      <= 1'b0;
    end else if (w_lock_lost) begin
      r_fail <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_fail      <= 1'b0;
            r_map       <= '0;
            r_pos       <= '0;
            r_up        <= 1'b1;
            r_dwell_cnt <= '0;
            r_err_seen  <= 1'b0;
          end
        end
        ST_DWELL: begin
          if (w_dwell_last) begin
            r_map       <= (r_map & ~w_pos_bit) | (w_dwell_pass ? w_pos_bit : '0);
            r_dwell_cnt <= '0;
            r_err_seen  <= 1'b0;
          end else begin
            r_dwell_cnt <= r_dwell_cnt + DWELL_W'(1);
            r_err_seen  <= r_err_seen | err_i;
          end
        end
        ST_STEP_ACK: begin
          if (w_hs_if.timeout)  r_fail <= 1'b1;
          else if (w_hs_if.ok)  r_pos  <= r_up ? (r_pos + POS_W'(1)) : (r_pos - POS_W'(1));
        end
        ST_EVAL: begin
          r_target <= w_eval_target;
          r_up     <= 1'b0;
          if (r_map == '0) r_fail <= 1'b1;
        end
        ST_DONE: r_best <= r_pos;
        default: ;
      endcase
    end
  end

  assign phasecounterselect = CNT_SEL;
  assign phasestep          = w_hs_if.phasestep;
  assign phaseupdown        = w_hs_if.phaseupdown;
  assign cal_busy           = (r_state != ST_IDLE);
  assign cal_done           = (r_state == ST_DONE);
  assign cal_fail           = r_fail;
  assign best_phase         = (r_state == ST_DONE) ? r_pos : r_best;

endmodule

// File: tb/tb_phase_cal_ctrl.sv
// Directed bench: a behavioural PLL answers phase steps and a receiver model raises err_i per phase.
module tb_phase_cal_ctrl;
  localparam int NUM_PH  = 8;
  localparam int DWELL   = 16;
  localparam int STEP_TO = 255;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       pll_lock;
  logic       cal_start;
  logic       err_i;
  logic [2:0] phasecounterselect;
  logic       cal_busy;
  logic       cal_done;
  logic       cal_fail;
  logic [3:0] best_phase;

  phase_cal_ctrl_if pll_if ();

  int n_chk = 0;
  int n_bad = 0;

  logic       m_clr;
  int         stuck_at;
  logic [7:0] err_mask;
  int         m_st, m_cnt, n_up, n_dn, n_req;
  logic       m_dir;
  logic [3:0] pll_ph;
  int         n_done, hi_run, max_hi;
  int         ud_viol = 0;
  logic       ud_ref;

  always #5 clk = ~clk;

  phase_cal_ctrl #(
    .NUM_PH (NUM_PH),
    .DWELL  (DWELL),
    .STEP_TO(STEP_TO),
    .CNT_SEL(3'b101)
  ) dut (
    .clk               (clk),
    .rst_i             (rst_i),
    .pll_lock          (pll_lock),
    .cal_start         (cal_start),
    .err_i             (err_i),
    .phasedone         (pll_if.phasedone),
    .phasecounterselect(phasecounterselect),
    .phasestep         (pll_if.phasestep),
    .phaseupdown       (pll_if.phaseupdown),
    .cal_busy          (cal_busy),
    .cal_done          (cal_done),
    .cal_fail          (cal_fail),
    .best_phase        (best_phase)
  );

  assign err_i = err_mask[pll_ph[2:0]];

  // PLL: drops phasedone one cycle after seeing phasestep, raises it 4 cycles later with the step applied.
  always @(posedge clk) begin
    if (m_clr) begin
      m_st <= 0; m_cnt <= 0; n_up <= 0; n_dn <= 0; n_req <= 0;
      pll_ph <= 4'd0; m_dir <= 1'b0; pll_if.phasedone <= 1'b1;
    end else if (m_st == 0) begin
      if (pll_if.phasestep && (n_req + 1 != stuck_at)) begin
        pll_if.phasedone <= 1'b0;
        m_dir <= pll_if.phaseupdown;
        n_req <= n_req + 1;
        m_cnt <= 3;
        m_st  <= 1;
      end
    end else begin
      if (m_cnt == 0) begin
        pll_if.phasedone <= 1'b1;
        if (m_dir) begin pll_ph <= pll_ph + 4'd1; n_up <= n_up + 1; end
        else       begin pll_ph <= pll_ph - 4'd1; n_dn <= n_dn + 1; end
        m_st <= 0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_clr) begin
      n_done <= 0; hi_run <= 0; max_hi <= 0;
    end else begin
      if (cal_done) n_done <= n_done + 1;
      if (pll_if.phasestep) begin
        hi_run <= hi_run + 1;
        if (hi_run + 1 > max_hi) max_hi <= hi_run + 1;
        if (hi_run == 0) ud_ref <= pll_if.phaseupdown;
        else if (pll_if.phaseupdown !== ud_ref) ud_viol <= ud_viol + 1;
      end else begin
        hi_run <= 0;
      end
    end
  end

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr_model();
    @(negedge clk); m_clr = 1'b1;
    repeat (2) @(negedge clk);
    m_clr = 1'b0;
  endtask

  task automatic run_cal(input string tag, output int b, output int f);
    b = -1; f = -1;
    @(negedge clk); cal_start = 1'b1;
    @(negedge clk); cal_start = 1'b0;
    for (int t = 0; t < 4000; t++) begin
      if (cal_done) begin b = best_phase; f = cal_fail; break; end
      @(negedge clk);
    end
    if (b < 0) chk_eq({tag, "_done_timeout"}, 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_step(input logic lvl, input string tag);
    int seen;
    seen = 0;
    for (int t = 0; t < 2000; t++) begin
      if (pll_if.phasestep == lvl) begin seen = 1; break; end
      @(negedge clk);
    end
    if (seen == 0) chk_eq(tag, 0, 1);
  endtask

  logic [7:0] masks  [4] = '{8'b1000_0011, 8'hFF, 8'b1001_1001, 8'b0111_1111};
  int         e_best [4] = '{4, 0, 1, 7};
  int         e_fail [4] = '{0, 1, 0, 0};
  int         e_dn   [4] = '{3, 7, 6, 0};

  initial begin
    int b, f, seen;
    rst_i = 1'b1; pll_lock = 1'b1; cal_start = 1'b0; m_clr = 1'b1;
    stuck_at = 0; err_mask = 8'h00;
    repeat (3) @(negedge clk);
    rst_i = 1'b0; m_clr = 1'b0;
    @(negedge clk);
    chk_eq("rst_phasestep", pll_if.phasestep, 0);
    chk_eq("rst_updown", pll_if.phaseupdown, 0);
    chk_eq("rst_cntsel", phasecounterselect, 5);
    chk_eq("rst_busy", cal_busy, 0);
    chk_eq("rst_done", cal_done, 0);
    chk_eq("rst_fail", cal_fail, 0);
    chk_eq("rst_best", best_phase, 0);

    for (int s = 0; s < 4; s++) begin
      err_mask = masks[s];
      clr_model();
      run_cal($sformatf("s%0d", s), b, f);
      chk_eq($sformatf("s%0d_best", s), b, e_best[s]);
      chk_eq($sformatf("s%0d_fail", s), f, e_fail[s]);
      chk_eq($sformatf("s%0d_ndone", s), n_done, 1);
      chk_eq($sformatf("s%0d_ups", s), n_up, 7);
      chk_eq($sformatf("s%0d_downs", s), n_dn, e_dn[s]);
      chk_eq($sformatf("s%0d_pllph", s), pll_ph, e_best[s]);
      chk_eq($sformatf("s%0d_idle", s), cal_busy, 0);
    end

    // third step never acknowledged
    err_mask = 8'h00; stuck_at = 3;
    clr_model();
    run_cal("to", b, f);
    chk_eq("to_best", b, 2);
    chk_eq("to_fail", f, 1);
    chk_eq("to_ndone", n_done, 1);
    chk_eq("to_step_le256", (max_hi <= 256) ? 1 : 0, 1);
    chk_eq("to_step_low", pll_if.phasestep, 0);
    stuck_at = 0;

    // lock lost while dwelling at position 5
    clr_model();
    @(negedge clk); cal_start = 1'b1;
    @(negedge clk); cal_start = 1'b0;
    seen = 0;
    for (int t = 0; t < 2000; t++) begin
      if (n_up == 5) begin seen = 1; break; end
      @(negedge clk);
    end
    chk_eq("lk_reach_pos5", seen, 1);
    repeat (4) @(negedge clk);
    pll_lock = 1'b0;
    b = -1; f = -1;
    for (int t = 0; t < 50; t++) begin
      if (cal_done) begin b = best_phase; f = cal_fail; break; end
      @(negedge clk);
    end
    chk_eq("lk_best", b, 5);
    chk_eq("lk_fail", f, 1);
    repeat (3) @(negedge clk);
    clr_model();
    @(negedge clk); cal_start = 1'b1;
    @(negedge clk); cal_start = 1'b0;
    repeat (20) @(negedge clk);
    chk_eq("nolock_busy", cal_busy, 0);
    chk_eq("nolock_ndone", n_done, 0);
    pll_lock = 1'b1;

    // reset while a step is being acknowledged
    clr_model();
    @(negedge clk); cal_start = 1'b1;
    @(negedge clk); cal_start = 1'b0;
    wait_step(1'b1, "rs_step_hi");
    wait_step(1'b0, "rs_step_lo");
    rst_i = 1'b1;
    @(negedge clk);
    chk_eq("rs_busy", cal_busy, 0);
    chk_eq("rs_phasestep", pll_if.phasestep, 0);
    chk_eq("rs_updown", pll_if.phaseupdown, 0);
    chk_eq("rs_fail", cal_fail, 0);
    chk_eq("rs_best", best_phase, 0);
    chk_eq("rs_done", cal_done, 0);
    rst_i = 1'b0;
    repeat (40) @(negedge clk);
    chk_eq("rs_ndone", n_done, 0);

    chk_eq("updown_stable", ud_viol, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/phase_cal_ctrl.md
PHASE_CAL_CTRL -- requirements
Module: phase_cal_ctrl

Interface
REQ-001 SHALL have parameter NUM_PH, default 8: number of phase positions swept, 2..16.
REQ-002 SHALL have parameter DWELL, default 1024: cycles err_i is observed per position, at least 2.
REQ-003 SHALL have parameter STEP_TO, default 255: maximum cycles for any wait inside one phase-step handshake.
REQ-004 SHALL have parameter CNT_SEL, default 3'b000: PLL counter being shifted.
REQ-005 SHALL have these ports, in this order:
- clk  in  1  single clock.
- rst_i  in  1  reset; synchronous and active-high.
- pll_lock  in  1  PLL locked.
- cal_start  in  1  1-cycle pulse that starts calibration.
- err_i  in  1  receiver error flag (ECC/CRC/sync error), level.
- phasedone  in  1  PLL handshake; low while a shift is in progress.
- phasecounterselect  out  3  always equals CNT_SEL.
- phasestep  out  1  PLL step request.
- phaseupdown  out  1  step direction; 1 = up (later), 0 = down.
- cal_busy  out  1  calibration in progress.
- cal_done  out  1  1-cycle pulse when calibration ends.
- cal_fail  out  1  sticky failure flag; cleared by the next start.
- best_phase  out  4  final phase index, 0..NUM_PH-1.

Function
REQ-006 SHALL accept cal_start only in IDLE and only with pll_lock=1; in any other case cal_start SHALL be ignored.
REQ-007 SHALL on an accepted start: clear cal_fail, pass_map and pos, then enter DWELL. Position 0 is the PLL phase at start.
REQ-008 SHALL implement states IDLE, DWELL, STEP_REQ, STEP_ACK, EVAL, MOVE, DONE.
REQ-009 DWELL SHALL last exactly DWELL cycles.
- If err_i is high in any of those cycles, pass_map[pos]=0; otherwise pass_map[pos]=1.
- Exit: to STEP_REQ (direction up) if pos<NUM_PH-1; else to EVAL.
REQ-010 Step handshake, STEP_REQ: phasestep=1 until phasedone is sampled low, then phasestep=0 and go to STEP_ACK.
REQ-011 Step handshake, STEP_ACK: wait for phasedone high, then update pos by +1 (up) or -1 (down).
REQ-012 SHALL, when STEP_REQ or STEP_ACK waits more than STEP_TO cycles: set cal_fail, deassert phasestep, go to DONE.
REQ-013 EVAL SHALL take at most NUM_PH+2 cycles and find the longest contiguous run of 1s in pass_map.
- No wrap-around.
- Ties resolve to the lowest start index.
- target = run_start + (run_len-1)/2, integer floor.
REQ-014 SHALL, when pass_map is all zero: set cal_fail and use target=0.
REQ-015 MOVE SHALL issue down-steps (phaseupdown=0) through the REQ-010/REQ-011 handshake until pos==target, then go to DONE; if target==NUM_PH-1, no steps are issued.
REQ-016 DONE SHALL last one cycle: cal_done=1, best_phase=pos, then return to IDLE.
REQ-017 SHALL keep cal_busy=1 in every state except IDLE.
REQ-018 SHALL, if pll_lock is 0 in any non-IDLE state: deassert phasestep next cycle, set cal_fail, go to DONE with best_phase=pos.
REQ-019 SHALL treat err_i only as a condition inside DWELL; err_i has no effect in other states.
REQ-020 phasestep SHALL never be high in IDLE, DWELL, EVAL or DONE.
REQ-021 phaseupdown SHALL be stable throughout any phasestep=1 interval.

Reset
REQ-022 On rst_i=1 at a clk edge, SHALL set:
- state=IDLE.
- phasestep=0, phaseupdown=0.
- phasecounterselect=CNT_SEL.
- cal_busy=0, cal_done=0, cal_fail=0, best_phase=0.
- pos=0, pass_map=0.
- all counters=0.
REQ-023 Reset asserted mid-calibration SHALL abort with no cal_done pulse.

Structure
REQ-024 SHALL place the state encoding and the widths of pos/timeout/dwell counters in shared package mipi_cal_pkg.
REQ-025 SHALL implement the phasestep/phasedone handshake and its timeout as sub-module pll_step_hs (inputs: go, dir; outputs: busy, ok, timeout).

Verification
REQ-026 Pass window: NUM_PH=8, DWELL=16, err_i high only at positions 0,1,7 -> 7 up-steps then 3 down-steps; best_phase=4, cal_fail=0, one cal_done pulse.
REQ-027 No pass: err_i always 1 -> 7 up-steps then 7 down-steps; best_phase=0, cal_fail=1.
REQ-028 Tie: pass at positions {1,2} and {5,6} -> target=1, best_phase=1.
REQ-029 Handshake timeout: phasedone held high after the 3rd phasestep -> phasestep drops within 256 cycles, cal_fail=1, cal_done=1, best_phase=2.
REQ-030 Lock loss: pll_lock falls during DWELL at pos=5 -> cal_fail=1, best_phase=5; cal_start with pll_lock=0 -> no response.
REQ-031 Reset: rst_i pulsed during STEP_ACK -> all outputs at reset values next cycle, no cal_done pulse.
